// File: rtl/mc_bus_bridge_pkg.sv
// Shared constants for the MCU parallel-bus bridge.
//   MC_DATA_WIDTH / MC_ADD_WIDTH / WQ_DEPTH : default bus and write-queue geometry
//   ADDR_DATA / ADDR_CMD                    : beat addresses decoded downstream; every other
//                                              address targets the register file
package mc_bus_bridge_pkg;

  localparam int unsigned MC_DATA_WIDTH = 16;
  localparam int unsigned MC_ADD_WIDTH  = 6;
  localparam int unsigned WQ_DEPTH      = 4;

  localparam logic [MC_ADD_WIDTH-1:0] ADDR_DATA = 6'h00;
  localparam logic [MC_ADD_WIDTH-1:0] ADDR_CMD  = 6'h01;

endpackage

// File: rtl/mc_bus_bridge_sync_edge.sv
// Synchroniser and falling-edge detector for one asynchronous active-low bus strobe.
//   clk_i, rst_i : system clock, asynchronous active-high reset
//   strobe_ni    : raw strobe from the pin (idle high)
//   sync_o       : strobe after the 2-FF synchroniser
//   fall_o       : one-cycle pulse on a synchronised high-to-low transition
// The detector only arms once a genuine high level has been seen after reset, so a strobe
// held low across reset release never produces an edge.
module mc_bus_bridge_sync_edge (
  input  logic clk_i,
  input  logic rst_i,
  input  logic strobe_ni,
  output logic sync_o,
  output logic fall_o
);

  logic       meta_q, sync_q, hist_q, armed_q;
  // fill_q[1] marks that sync_q now holds a real pin sample rather than its reset value.
  logic [1:0] fill_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q  <= 1'b1;
      sync_q  <= 1'b1;
      hist_q  <= 1'b1;
      armed_q <= 1'b0;
      fill_q  <= 2'b00;
    end else begin
      meta_q <= strobe_ni;
      sync_q <= meta_q;
      hist_q <= sync_q;
      fill_q <= {fill_q[0], 1'b1};
      if (fill_q[1] && sync_q) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign sync_o = sync_q;
  assign fall_o = armed_q & hist_q & ~sync_q;

endmodule

// File: rtl/mc_bus_bridge.sv
// Front end between the MCU external parallel memory bus and the internal command/register
// fabric.
//   clk_i, rst_i             : system clock, asynchronous active-high reset
//   mc_ce_ni/we_ni/oe_ni     : asynchronous active-low bus strobes
//   mc_add_i, mc_data_io     : bus address and bidirectional data
//   wr_valid_o/ready_i       : write-beat handshake, beat in wr_addr_o/wr_data_o
//   rd_req_o, rd_addr_o      : one-cycle read request and its held address
//   rd_data_i                : read data, valid the cycle after rd_req_o
//   clear_i                  : synchronous flush of the queue and sticky flags
//   wq_overflow_o            : sticky, a write was dropped on a full queue
//   bus_error_o              : sticky, write and read strobes asserted together
module mc_bus_bridge
  import mc_bus_bridge_pkg::*;
#(
  parameter int unsigned McDataWidth = MC_DATA_WIDTH,
  parameter int unsigned McAddWidth  = MC_ADD_WIDTH,
  parameter int unsigned WqDepth     = WQ_DEPTH
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   mc_ce_ni,
  input  logic                   mc_we_ni,
  input  logic                   mc_oe_ni,
  input  logic [McAddWidth-1:0]  mc_add_i,
  inout  wire  [McDataWidth-1:0] mc_data_io,
  output logic                   wr_valid_o,
  input  logic                   wr_ready_i,
  output logic [McAddWidth-1:0]  wr_addr_o,
  output logic [McDataWidth-1:0] wr_data_o,
  output logic                   rd_req_o,
  output logic [McAddWidth-1:0]  rd_addr_o,
  input  logic [McDataWidth-1:0] rd_data_i,
  input  logic                   clear_i,
  output logic                   wq_overflow_o,
  output logic                   bus_error_o
);

  localparam int unsigned PtrW = $clog2(WqDepth);
  localparam logic [PtrW:0] PtrOne = (PtrW + 1)'(1);

  // Strobe synchronisation and edge detection.
  logic ce_meta_q, ce_sync_q;
  logic we_sync, we_fall, oe_sync, oe_fall;
  logic we_fire, oe_fire, both_low;

  mc_bus_bridge_sync_edge u_we_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .strobe_ni (mc_we_ni),
    .sync_o    (we_sync),
    .fall_o    (we_fall)
  );

  mc_bus_bridge_sync_edge u_oe_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .strobe_ni (mc_oe_ni),
    .sync_o    (oe_sync),
    .fall_o    (oe_fall)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ce_meta_q <= 1'b1;
      ce_sync_q <= 1'b1;
    end else begin
      ce_meta_q <= mc_ce_ni;
      ce_sync_q <= ce_meta_q;
    end
  end

  // A simultaneous write edge wins; the read is discarded.
  assign we_fire  = we_fall & ~ce_sync_q;
  assign oe_fire  = oe_fall & ~ce_sync_q & ~we_fire;
  assign both_low = ~we_sync & ~oe_sync & ~ce_sync_q;

  // Write queue: circular buffer, pointers carry one extra wrap bit.
  logic [McAddWidth-1:0]  addr_mem_q [WqDepth];
  logic [McDataWidth-1:0] data_mem_q [WqDepth];
  logic [PtrW:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic                   ovf_q, ovf_d, berr_q, berr_d;
  logic                   empty, full, pop, push;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign pop   = ~empty & wr_ready_i;
  // A pop in the same cycle frees the slot, so a full queue still accepts the push.
  assign push  = we_fire & (~full | pop) & ~clear_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    berr_d   = berr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
      berr_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrOne;
      if (pop) rd_ptr_d = rd_ptr_q + PtrOne;
      if (we_fire && !push) ovf_d = 1'b1;
      if (both_low) berr_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      berr_q   <= 1'b0;
      for (int unsigned i = 0; i < WqDepth; i++) begin
        addr_mem_q[i] <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      berr_q   <= berr_d;
      // Address and data are taken straight from the pins; the bus holds them stable well
      // before the strobe, so the synchroniser delay does not matter here.
      if (push) begin
        addr_mem_q[wr_ptr_q[PtrW-1:0]] <= mc_add_i;
        data_mem_q[wr_ptr_q[PtrW-1:0]] <= mc_data_io;
      end
    end
  end

  assign wr_valid_o    = ~empty;
  assign wr_addr_o     = addr_mem_q[rd_ptr_q[PtrW-1:0]];
  assign wr_data_o     = data_mem_q[rd_ptr_q[PtrW-1:0]];
  assign wq_overflow_o = ovf_q;
  assign bus_error_o   = berr_q;

  // Read path: request pulse, then capture the returned word one cycle later.
  logic                   rd_req_q, rd_pend_q;
  logic [McAddWidth-1:0]  rd_addr_q;
  logic [McDataWidth-1:0] rd_hold_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_req_q  <= 1'b0;
      rd_pend_q <= 1'b0;
      rd_addr_q <= '0;
      rd_hold_q <= '0;
    end else begin
      rd_req_q  <= oe_fire;
      rd_pend_q <= rd_req_q;
      if (oe_fire) rd_addr_q <= mc_add_i;
      if (rd_pend_q) rd_hold_q <= rd_data_i;
    end
  end

  assign rd_req_o  = rd_req_q;
  assign rd_addr_o = rd_addr_q;

  // Drive from the raw pins so the bus releases as soon as the MCU deasserts.
  assign mc_data_io = (~mc_oe_ni & ~mc_ce_ni) ? rd_hold_q : {McDataWidth{1'bz}};

endmodule

// File: tb/tb_mc_bus_bridge.sv
// Self-checking bench for mc_bus_bridge: bus-cycle tasks, a vector table, hand-timed corner
// sequences and a randomized phase checked against a beat-queue model.
module tb_mc_bus_bridge;
  import mc_bus_bridge_pkg::*;

  localparam int DW    = 16;
  localparam int AW    = 6;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          mc_ce_n = 1'b1, mc_we_n = 1'b1, mc_oe_n = 1'b1;
  logic [AW-1:0] mc_add = '0;
  wire  [DW-1:0] mc_data;
  logic          tb_drv = 1'b0;
  logic [DW-1:0] tb_dout = '0;
  logic          wr_valid, wr_ready = 1'b1;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          rd_req, clear = 1'b0, wq_overflow, bus_error;

  always #5 clk = ~clk;

  assign mc_data = tb_drv ? tb_dout : {DW{1'bz}};
  for (genvar g = 0; g < DW; g++) begin : g_pull
    pullup (mc_data[g]);
  end

  mc_bus_bridge dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .mc_ce_ni      (mc_ce_n),
    .mc_we_ni      (mc_we_n),
    .mc_oe_ni      (mc_oe_n),
    .mc_add_i      (mc_add),
    .mc_data_io    (mc_data),
    .wr_valid_o    (wr_valid),
    .wr_ready_i    (wr_ready),
    .wr_addr_o     (wr_addr),
    .wr_data_o     (wr_data),
    .rd_req_o      (rd_req),
    .rd_addr_o     (rd_addr),
    .rd_data_i     (rd_data),
    .clear_i       (clear),
    .wq_overflow_o (wq_overflow),
    .bus_error_o   (bus_error)
  );

  // Read responder: returns memory contents the cycle after rd_req, junk otherwise.
  logic [DW-1:0] rmem [64];
  always @(posedge clk) rd_data <= rd_req ? rmem[rd_addr] : DW'($urandom);

  int n_checks = 0, n_pass = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Model: ordered list of beats the bridge still owes the consumer.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } beat_t;
  beat_t exp_q[$];
  int    beats_seen = 0, rdreq_seen = 0;
  bit    rand_ready = 1'b0;

  task automatic model_write(input bit ce_n, input logic [AW-1:0] a, input logic [DW-1:0] d);
    beat_t b;
    if (!ce_n && exp_q.size() < DEPTH) begin
      b.a = a;
      b.d = d;
      exp_q.push_back(b);
    end
  endtask

  // Monitor samples 2ns after the falling edge, once stimulus has settled.
  bit                  stall_prev = 1'b0;
  logic [AW+DW-1:0]    stall_val;
  always begin : mon
    beat_t b;
    @(negedge clk);
    #2;
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) check("wr_hold", {wr_valid, wr_addr, wr_data}, {1'b1, stall_val});
      if (wr_valid && wr_ready) begin
        beats_seen++;
        if (exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL beat_unexpected: got 0x%0h/0x%0h expected none", wr_addr, wr_data);
        end else begin
          b = exp_q.pop_front();
          check("beat", {wr_addr, wr_data}, {b.a, b.d});
        end
      end
      stall_prev = wr_valid && !wr_ready;
      stall_val  = {wr_addr, wr_data};
      if (rd_req) rdreq_seen++;
    end
  end

  task automatic tick();
    @(negedge clk);
    if (rand_ready) wr_ready = ($urandom_range(3) != 0);
  endtask

  // Full bus cycle: 3 clocks setup, 6 clocks strobe low, 3 clocks hold.
  task automatic bus_cycle(input bit rd, input bit ce_n, input logic [AW-1:0] a,
                           input logic [DW-1:0] d, output logic [DW-1:0] seen);
    mc_ce_n = ce_n;
    mc_add  = a;
    if (rd) rmem[a] = d;
    else begin
      tb_dout = d;
      tb_drv  = 1'b1;
    end
    repeat (3) tick();
    if (rd) mc_oe_n = 1'b0;
    else begin
      mc_we_n = 1'b0;
      model_write(ce_n, a, d);
    end
    repeat (6) tick();
    seen    = mc_data;
    mc_oe_n = 1'b1;
    mc_we_n = 1'b1;
    repeat (3) tick();
    tb_drv  = 1'b0;
    mc_ce_n = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (3) tick();
    exp_q.delete();
    rst = 1'b0;
    repeat (5) tick();
  endtask

  typedef struct {
    bit            rd;
    bit            ce_n;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            exp_beats;
    int            exp_rdreq;
    logic [DW-1:0] exp_md;
  } vec_t;
  vec_t vecs[8];

  initial begin
    logic [DW-1:0] s;
    int            b0, r0;
    bit            rd, ce_n;
    logic [AW-1:0] a;
    logic [DW-1:0] d;

    vecs[0] = '{0, 0, 6'h01, 16'h0080, 1, 0, 16'h0080};
    vecs[1] = '{0, 0, 6'h00, 16'hBEEF, 1, 0, 16'hBEEF};
    vecs[2] = '{1, 0, 6'h02, 16'hA5A5, 0, 1, 16'hA5A5};
    vecs[3] = '{1, 0, 6'h3F, 16'h1234, 0, 1, 16'h1234};
    vecs[4] = '{0, 1, 6'h05, 16'h5555, 0, 0, 16'h5555};
    vecs[5] = '{1, 1, 6'h07, 16'h7777, 0, 0, 16'hFFFF};
    vecs[6] = '{0, 0, 6'h3E, 16'hFFFF, 1, 0, 16'hFFFF};
    vecs[7] = '{1, 0, 6'h00, 16'h0000, 0, 1, 16'h0000};
    for (int i = 0; i < 64; i++) rmem[i] = DW'($urandom);

    rst = 1'b1;
    repeat (3) tick();
    check("rst_wr_valid", wr_valid, 0);
    check("rst_outs", {rd_req, rd_addr, wr_addr, wr_data}, 0);
    check("rst_flags", {wq_overflow, bus_error}, 0);
    check("rst_hiz", mc_data, 16'hFFFF);
    rst = 1'b0;
    repeat (5) tick();

    // Write latency: strobe falls between edges n-1 and n, wr_valid visible after n+2.
    b0      = beats_seen;
    mc_ce_n = 1'b0;
    mc_add  = ADDR_CMD;
    tb_dout = 16'h0080;
    tb_drv  = 1'b1;
    repeat (3) tick();
    mc_we_n = 1'b0;
    model_write(1'b0, ADDR_CMD, 16'h0080);
    tick(); check("t1_valid_k1", wr_valid, 0);
    tick(); check("t1_valid_k2", wr_valid, 0);
    tick(); check("t1_valid_k3", wr_valid, 1);
    check("t1_beat", {wr_addr, wr_data}, {ADDR_CMD, 16'h0080});
    tick(); check("t1_valid_k4", wr_valid, 0);
    repeat (2) tick();
    mc_we_n = 1'b1;
    repeat (3) tick();
    tb_drv  = 1'b0;
    mc_ce_n = 1'b1;
    repeat (2) tick();
    check("t1_beats", beats_seen - b0, 1);

    // Read latency and bus release.
    r0       = rdreq_seen;
    rmem[2]  = 16'hA5A5;
    mc_ce_n  = 1'b0;
    mc_add   = 6'h02;
    repeat (3) tick();
    mc_oe_n = 1'b0;
    tick(); check("t2_req_k1", rd_req, 0);
    tick(); check("t2_req_k2", rd_req, 0);
    tick(); check("t2_req_k3", rd_req, 1);
    check("t2_rd_addr", rd_addr, 6'h02);
    tick(); check("t2_req_k4", rd_req, 0);
    tick(); check("t2_data_k5", mc_data, 16'hA5A5);
    tick(); check("t2_data_k6", mc_data, 16'hA5A5);
    mc_oe_n = 1'b1;
    tick(); check("t2_hiz", mc_data, 16'hFFFF);
    repeat (2) tick();
    mc_ce_n = 1'b1;
    check("t2_reqs", rdreq_seen - r0, 1);

    // Vector table.
    for (int i = 0; i < 8; i++) begin
      b0 = beats_seen;
      r0 = rdreq_seen;
      bus_cycle(vecs[i].rd, vecs[i].ce_n, vecs[i].a, vecs[i].d, s);
      repeat (3) tick();
      check($sformatf("vec%0d_mc_data", i), s, vecs[i].exp_md);
      check($sformatf("vec%0d_beats", i), beats_seen - b0, vecs[i].exp_beats);
      check($sformatf("vec%0d_rdreq", i), rdreq_seen - r0, vecs[i].exp_rdreq);
      if (vecs[i].exp_rdreq != 0) check($sformatf("vec%0d_rd_addr", i), rd_addr, vecs[i].a);
      check($sformatf("vec%0d_hiz", i), mc_data, 16'hFFFF);
    end
    check("vec_flags", {wq_overflow, bus_error}, 0);

    // Overflow: five writes into a stalled four-entry queue.
    wr_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus_cycle(1'b0, 1'b0, 6'h02, 16'(i), s);
      if (i == 3) check("ovf_not_yet", wq_overflow, 0);
    end
    check("ovf_set", wq_overflow, 1);
    check("ovf_head", {wr_valid, wr_data}, {1'b1, 16'h0000});
    wr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d", i), {wr_valid, wr_data}, {1'b1, 16'(i)});
      tick();
    end
    check("drain_empty", wr_valid, 0);
    check("ovf_sticky", wq_overflow, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check("ovf_cleared", wq_overflow, 0);

    // Strobe held low across reset release must not fire until it has been seen high.
    mc_ce_n = 1'b0;
    mc_add  = 6'h03;
    tb_dout = 16'hCAFE;
    tb_drv  = 1'b1;
    mc_we_n = 1'b0;
    rst     = 1'b1;
    repeat (3) tick();
    exp_q.delete();
    rst = 1'b0;
    b0  = beats_seen;
    repeat (10) tick();
    check("arm_no_beat", beats_seen - b0, 0);
    check("arm_no_valid", wr_valid, 0);
    mc_we_n = 1'b1;
    repeat (4) tick();
    mc_we_n = 1'b0;
    model_write(1'b0, 6'h03, 16'hCAFE);
    repeat (6) tick();
    mc_we_n = 1'b1;
    repeat (3) tick();
    tb_drv  = 1'b0;
    mc_ce_n = 1'b1;
    repeat (3) tick();
    check("arm_one_beat", beats_seen - b0, 1);

    // Randomized traffic with a randomly stalling consumer.
    rand_ready = 1'b1;
    for (int i = 0; i < 30; i++) begin
      rd   = 1'($urandom_range(1));
      ce_n = ($urandom_range(7) == 0);
      a    = AW'($urandom);
      d    = DW'($urandom);
      r0   = rdreq_seen;
      bus_cycle(rd, ce_n, a, d, s);
      if (rd) begin
        check("rnd_rd_data", s, ce_n ? 16'hFFFF : d);
        check("rnd_rdreq", rdreq_seen - r0, ce_n ? 0 : 1);
      end
    end
    rand_ready = 1'b0;
    wr_ready   = 1'b1;
    repeat (6) tick();
    check("rnd_drained", exp_q.size(), 0);
    check("rnd_flags", {wq_overflow, bus_error}, 0);

    // Write and read strobes together: write wins, read dropped, error flagged.
    do_reset();
    b0      = beats_seen;
    r0      = rdreq_seen;
    mc_ce_n = 1'b0;
    mc_add  = ADDR_DATA;
    tb_dout = 16'h1234;
    tb_drv  = 1'b1;
    repeat (3) tick();
    mc_we_n = 1'b0;
    mc_oe_n = 1'b0;
    model_write(1'b0, ADDR_DATA, 16'h1234);
    repeat (6) tick();
    mc_we_n = 1'b1;
    mc_oe_n = 1'b1;
    repeat (3) tick();
    tb_drv  = 1'b0;
    mc_ce_n = 1'b1;
    repeat (3) tick();
    check("berr_beats", beats_seen - b0, 1);
    check("berr_no_rdreq", rdreq_seen - r0, 0);
    check("berr_set", bus_error, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    check("berr_cleared", bus_error, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/mc_bus_bridge.md
# mc_bus_bridge

Clock-domain front end between the MCU external parallel memory bus (mc_add/mc_data/mc_we/mc_oe/mc_ce) and the internal command/register fabric of top. Synchronises the asynchronous active-low strobes, turns each bus write into one queued write beat (address + data) for the command FIFO / register file, and turns each bus read into a one-cycle read request whose returned data it drives back onto mc_data. Sits directly upstream of the command decoder that consumes CMD_* words.

## Interface
- MC_DATA_WIDTH, 16, bus data width
- MC_ADD_WIDTH, 6, bus address width
- WQ_DEPTH, 4, write-queue entries (power of two, ≥2)

- clock  in  1  system clock
- reset  in  1  asynchronous, active-high
- mc_ce  in  1  chip enable, active low
- mc_we  in  1  write strobe, active low
- mc_oe  in  1  output enable, active low
- mc_add  in  MC_ADD_WIDTH  bus address
- mc_data  inout  MC_DATA_WIDTH  bus data; driven only while mc_oe=0 and mc_ce=0
- wr_valid  out  1  write beat available
- wr_ready  in  1  consumer accepts beat
- wr_addr  out  MC_ADD_WIDTH  beat address (0x00 data, 0x01 command, others register)
- wr_data  out  MC_DATA_WIDTH  beat data
- rd_req  out  1  one-cycle read request pulse
- rd_addr  out  MC_ADD_WIDTH  read address, held until next rd_req
- rd_data  in  MC_DATA_WIDTH  read data, valid exactly 1 cycle after rd_req
- clear  in  1  synchronous flush (bp_fifo_clear)
- wq_overflow  out  1  sticky: write dropped, queue full
- bus_error  out  1  sticky: mc_we and mc_oe both asserted

## Operation
- mc_we, mc_oe each pass a 2-FF synchroniser (reset to 1 = idle) plus a third history FF; falling edge = history 1, sync 0, qualified by mc_ce=0 sampled at sync stage (mc_ce also 2-FF synced).
- Arming: after reset each strobe must be seen high once before its edge detector is armed; strobe held low across reset release never fires.
- Write edge: capture mc_add/mc_data directly from pins (stable ≥3 clocks before strobe by bus contract) and push into WQ_DEPTH FIFO.
- Queue full on push: beat dropped, wq_overflow set. Push and pop in same cycle while full: push accepted.
- Output handshake: beat transfers on wr_valid & wr_ready; wr_addr/wr_data stable while wr_valid & !wr_ready.
- Read edge: rd_addr <= mc_add, rd_req pulses 1 cycle; next cycle rd_data latched into rd_hold. mc_data = rd_hold when raw mc_oe=0 and raw mc_ce=0, else high-Z.
- Write and read edges in same cycle: write taken, read ignored, bus_error set.
- clear: empties queue, clears both sticky flags; clear wins over simultaneous push and flag set.
- Reset values: wr_valid 0, wr_addr 0, wr_data 0, rd_req 0, rd_addr 0, rd_hold 0, wq_overflow 0, bus_error 0, mc_data high-Z, queue empty, detectors disarmed.

## Timing
- mc_we falling between clocks n-1 and n: edge detected at clock n+2, push at n+2, wr_valid=1 from n+3.
- mc_oe falling likewise: rd_req high in cycle n+3, rd_hold updated at n+4 edge, correct data on mc_data from n+4; bus must hold mc_oe low ≥6 clocks.
- Minimum strobe low width and high gap: 3 clocks each; shorter pulses may be missed (no error flagged).
- Throughput: one beat per clock out of queue; one bus write per 6 clocks in.

## Structure
- Shared package/include (registers.v): address constants ADDR_DATA=0x00, ADDR_CMD=0x01.
- Sub-module sync_edge (2-FF sync + history + arming + falling-edge pulse), instantiated for we, oe; ce uses sync only.
- Queue is inline circular buffer with log2(WQ_DEPTH)+1-bit pointers.

## Test plan
- Write addr 0x01 data 0x0080 with wr_ready=1 (3 setup/6 low/3 hold clocks) -> single beat addr 0x01 data 0x0080, wr_valid high 1 cycle at n+3.
- wr_ready=0, five writes 0x0000..0x0004 -> first four queued in order, fifth dropped, wq_overflow=1; raise wr_ready -> 0..3 drained on 4 consecutive cycles; pulse clear -> wq_overflow=0.
- Read addr 0x02 with rd_data model returning 0xA5A5 -> rd_req once, rd_addr=0x02, mc_data=0xA5A5 before mc_oe rises, high-Z after.
- mc_we and mc_oe pulled low together, addr 0x00 data 0x1234 -> one write beat 0x1234, no rd_req, bus_error=1.
- Hold mc_we low through reset deassertion -> no beat; release and reassert -> exactly one beat.
- mc_ce=1 during full write and read cycle -> no beat, no rd_req, mc_data high-Z.
